// File: rtl/input_synchronizer_pkg.sv
// Shared constants for the traffic light controller front end.
// Controller-level blocks import this so every synchronizer agrees on depth.
package input_synchronizer_pkg;

  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int SYNC_STAGES_MIN     = 2;
  localparam int SYNC_STAGES_MAX     = 4;

endpackage

// File: rtl/input_synchronizer_sync_cell.sv
// One-bit synchronizer chain with asynchronous clear to RESET_VAL.
// The last flop drives o_q directly, and each flop feeds only the next stage.
module sync_cell
  import input_synchronizer_pkg::*;
#(
  parameter int   DEPTH     = SYNC_STAGES_DEFAULT,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE" *) logic [DEPTH-1:0] r_chain;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_chain <= {DEPTH{RESET_VAL}};
    end else begin
      r_chain <= {r_chain[DEPTH-2:0], i_d};
    end
  end

  assign o_q = r_chain[DEPTH-1];

endmodule

// File: rtl/input_synchronizer.sv
// Brings Reset, Sensor, Walk_Request and Reprogram into the clk domain.
// Reset_Sync asserts asynchronously and deasserts after SYNC_STAGES edges.
module input_synchronizer
  import input_synchronizer_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic Reset,
  input  logic Sensor,
  input  logic Walk_Request,
  input  logic Reprogram,
  output logic Prog_Sync,
  output logic WR_Sync,
  output logic Sensor_Sync,
  output logic Reset_Sync
);

  // Reset channel shifts in 0 so release is synchronous to clk.
  sync_cell #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_reset (
    .i_clk (clk),
    .i_rst (Reset),
    .i_d   (1'b0),
    .o_q   (Reset_Sync)
  );

  sync_cell #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sensor (
    .i_clk (clk),
    .i_rst (Reset),
    .i_d   (Sensor),
    .o_q   (Sensor_Sync)
  );

  sync_cell #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_walk (
    .i_clk (clk),
    .i_rst (Reset),
    .i_d   (Walk_Request),
    .o_q   (WR_Sync)
  );

  sync_cell #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_prog (
    .i_clk (clk),
    .i_rst (Reset),
    .i_d   (Reprogram),
    .o_q   (Prog_Sync)
  );

endmodule

// File: tb/tb_input_synchronizer.sv
// Bench for input_synchronizer at depth 2 and depth 3 sharing one stimulus.
// Output vectors are packed as {Reset_Sync, Prog_Sync, WR_Sync, Sensor_Sync}.
module tb_input_synchronizer;

  logic clk;
  logic reset;
  logic sensor;
  logic walk_request;
  logic reprogram;

  logic prog_sync2, wr_sync2, sensor_sync2, reset_sync2;
  logic prog_sync3, wr_sync3, sensor_sync3, reset_sync3;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_q2[$];
  logic [3:0] exp_q3[$];

  input_synchronizer #(.SYNC_STAGES(2)) dut2 (
    .clk          (clk),
    .Reset        (reset),
    .Sensor       (sensor),
    .Walk_Request (walk_request),
    .Reprogram    (reprogram),
    .Prog_Sync    (prog_sync2),
    .WR_Sync      (wr_sync2),
    .Sensor_Sync  (sensor_sync2),
    .Reset_Sync   (reset_sync2)
  );

  input_synchronizer #(.SYNC_STAGES(3)) dut3 (
    .clk          (clk),
    .Reset        (reset),
    .Sensor       (sensor),
    .Walk_Request (walk_request),
    .Reprogram    (reprogram),
    .Prog_Sync    (prog_sync3),
    .WR_Sync      (wr_sync3),
    .Sensor_Sync  (sensor_sync3),
    .Reset_Sync   (reset_sync3)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] out2();
    return {reset_sync2, prog_sync2, wr_sync2, sensor_sync2};
  endfunction

  function automatic logic [3:0] out3();
    return {reset_sync3, prog_sync3, wr_sync3, sensor_sync3};
  endfunction

  // Reset state: depth-1 entries of "in reset" precede the first real sample.
  function automatic void sb_reset();
    exp_q2.delete();
    exp_q3.delete();
    exp_q2.push_back(4'b1000);
    exp_q3.push_back(4'b1000);
    exp_q3.push_back(4'b1000);
  endfunction

  // Scoreboard: push the sampled inputs at each edge, pop what is due now.
  always @(posedge clk) begin
    logic [3:0] smp;
    if (!reset) begin
      smp = {1'b0, reprogram, walk_request, sensor};
      exp_q2.push_back(smp);
      exp_q3.push_back(smp);
      #1;
      if (exp_q2.size() == 0) check_val("q2_underflow", 4'b0001, 4'b0000);
      else check_val("sb_depth2", out2(), exp_q2.pop_front());
      if (exp_q3.size() == 0) check_val("q3_underflow", 4'b0001, 4'b0000);
      else check_val("sb_depth3", out3(), exp_q3.pop_front());
    end
  end

  // Driver tasks: inputs change on the falling edge, away from capture.
  task automatic drive(input logic s, input logic w, input logic p);
    @(negedge clk);
    sensor       = s;
    walk_request = w;
    reprogram    = p;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_in_reset(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      check_val({tag, "_d2"}, out2(), 4'b1000);
      check_val({tag, "_d3"}, out3(), 4'b1000);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("release_d2", out2(), 4'b1000);
    check_val("release_d3", out3(), 4'b1000);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    sb_reset();
    #1;
    check_val("async_rst_d2", out2(), 4'b1000);
    check_val("async_rst_d3", out3(), 4'b1000);
  endtask

  initial begin
    reset        = 1'b1;
    sensor       = 1'b0;
    walk_request = 1'b0;
    reprogram    = 1'b0;
    sb_reset();

    // Power-up reset with inputs low, then inputs high while still in reset.
    check_in_reset("por_low", 9);
    #4;
    sensor       = 1'b1;
    walk_request = 1'b1;
    reprogram    = 1'b1;
    check_in_reset("por_high", 12);

    // Release with inputs already high; reset and data latency checked by scoreboard.
    release_reset();
    idle(5);

    // Sensor rising alone.
    drive(1'b0, 1'b0, 1'b0);
    idle(4);
    drive(1'b1, 1'b0, 1'b0);
    idle(4);

    // Walk_Request pulse of exactly three cycles.
    drive(1'b1, 1'b1, 1'b0);
    idle(2);
    drive(1'b1, 1'b0, 1'b0);
    idle(5);

    // Simultaneous changes on all channels.
    drive(1'b0, 1'b1, 1'b1);
    idle(1);
    drive(1'b1, 1'b0, 1'b0);
    idle(4);

    // Async reset mid-cycle with all outputs at 1.
    drive(1'b1, 1'b1, 1'b1);
    idle(5);
    async_reset();
    check_in_reset("hold_rst", 4);

    // Re-assert reset while the reset chain is still draining.
    release_reset();
    @(posedge clk);
    #3;
    async_reset();
    check_in_reset("midchain", 3);

    // Random single-cycle and multi-cycle activity.
    release_reset();
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog against a stalled run.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
